mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit consuming the EX/MEM pipeline register outputs. Turns a load or store held in MEM into a valid/ready transaction on an external data-memory bus. Generates byte enables and store-data lane replication, and sign/zero-extends load data. Stalls the pipeline until the access completes, faults or times out.

## Interface
- BUS_TIMEOUT, 255: cycles spent in REQ+WAIT_RSP before an access is abandoned; range 1..255.
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemWriteM  in  1  store in MEM.
- ResultSrcM  in  2  value 2'b01 marks a load in MEM.
- funct3M  in  3  access size: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_req_be  out  4  byte enables.
- mem_req_wdata  out  32  lane-replicated store data.
- mem_rsp_valid  in  1  load data valid.
- mem_rsp_rdata  in  32  load data word.
- ReadDataM  out  32  extended load result.
- StallM  out  1  holds IF/ID/EX/MEM stages.
- AccessFaultM  out  1  misaligned access or unsupported funct3.
- BusErrM  out  1  access abandoned on timeout.

## Operation
- access = MemWriteM | (ResultSrcM==2'b01); a store with the load code still counts as a store.
- fault, evaluated in IDLE: funct3 in {011,110,111}, halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: access & !fault -> REQ; capture addr, we, be, wdata and funct3 into registers; clear timeout counter.
- IDLE: access & fault -> AccessFaultM=1 combinationally, StallM=0, no bus request, stay IDLE.
- REQ: mem_req_valid=1 with stable registered fields until handshake.
- REQ: handshake on a write -> DONE (posted write). Handshake on a read -> WAIT_RSP.
- WAIT_RSP: mem_rsp_valid -> capture rdata, go DONE. mem_rsp_valid is ignored outside WAIT_RSP.
- Timeout: counter increments every cycle in REQ/WAIT_RSP. When it reaches BUS_TIMEOUT -> DONE with error flag set, captured data = 0, mem_req_valid deasserted.
- DONE: StallM=0, ReadDataM valid, BusErrM = error flag; then -> IDLE.
- Byte enables:
  - byte access: be=4'b0001<<addr[1:0]; wdata={4{WriteDataM[7:0]}}.
  - halfword access: be = addr[1] ? 4'b1100 : 4'b0011; wdata={2{WriteDataM[15:0]}}.
  - word access: be=4'b1111; wdata=WriteDataM.
- Loads use the same be. Load lane = rdata >> (8*addr[1:0]).
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.

## Timing
- StallM = (IDLE & access & !fault) | REQ | WAIT_RSP; combinational.
- ReadDataM is nonzero only in DONE for loads; 0 in all other states and for stores.
- BusErrM is asserted only in DONE.
- Minimum latency, load: IDLE c0, REQ c1 (ready=1), WAIT_RSP c2 (rsp_valid=1), DONE c3. The instruction leaves MEM at the end of c3, after 3 stall cycles.
- Minimum latency, store: IDLE c0, REQ c1 handshake, DONE c2. 2 stall cycles.
- A response in the handshake cycle is ignored; the earliest usable response comes the cycle after the handshake.
- Back-to-back accesses: DONE -> IDLE. The next access starts the cycle after DONE; no bus request in DONE.
- Reset values: state IDLE; mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata = 0; captured data 0; counter 0; ReadDataM, BusErrM = 0.
- Reset mid-transaction: asynchronous return to IDLE, mem_req_valid drops immediately. The outstanding response is dropped because it arrives in IDLE.

## Test plan
- LW addr 0x100, ready=1 in c1, rsp rdata 0xDEADBEEF in c2 -> req_addr 0x100, be 1111; StallM high c0-c2; ReadDataM 0xDEADBEEF in c3.
- SB addr 0x203, data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5, we=1; StallM high 2 cycles; ReadDataM 0.
- LB addr 0x2, rdata 0x00800000 -> ReadDataM 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x2, rdata 0x80010000 -> 0xFFFF8001.
- LW addr 0x101 -> AccessFaultM=1, StallM=0, mem_req_valid never asserted. funct3=011 gives the same result.
- BUS_TIMEOUT=4, ready held 0 -> StallM for 1+4 cycles, then DONE with BusErrM=1, ReadDataM=0. A late rsp_valid is ignored.
- rst_n low while in WAIT_RSP -> mem_req_valid=0 and state IDLE immediately. A following rsp_valid changes no output.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives one valid/ready data-memory access per load/store and extends load data.
// Latency: load 3 stall cycles, store 2; stalls while the bus withholds ready/response, abandons after BUS_TIMEOUT cycles.
module mem_access_unit #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AccessFaultM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        access;
  logic        fault;
  logic        tmo;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] lane;

  always_comb begin
    access = MemWriteM | (ResultSrcM == 2'b01);
    case (funct3M)
      3'b011, 3'b110, 3'b111: fault = 1'b1;
      3'b001, 3'b101:         fault = ALUResultM[0];
      3'b010:                 fault = |ALUResultM[1:0];
      default:                fault = 1'b0;
    endcase
    case (funct3M[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << ALUResultM[1:0];
        wdata_calc = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_calc    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = WriteDataM;
      end
    endcase
  end

  // Completion (write handshake or read response) wins over a timeout in the same cycle.
  assign tmo = ({1'b0, cnt_q} + 9'd1) >= 9'(BUS_TIMEOUT);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (access && !fault) begin
          state_d  = REQ;
          addr_d   = ALUResultM;
          we_d     = MemWriteM;
          be_d     = be_calc;
          wdata_d  = wdata_calc;
          funct3_d = funct3M;
          cnt_d    = 8'd0;
          rdata_d  = 32'd0;
          err_d    = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_req_ready && we_q) begin
          state_d = DONE;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else if (mem_req_ready) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rsp_valid) begin
          state_d = DONE;
          rdata_d = mem_rsp_rdata;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      cnt_q    <= 8'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_be    = be_q;
  assign mem_req_wdata = wdata_q;

  assign StallM       = ((state_q == IDLE) && access && !fault) || (state_q == REQ) || (state_q == WAIT_RSP);
  assign AccessFaultM = (state_q == IDLE) && access && fault;
  assign BusErrM      = (state_q == DONE) && err_q;

  // Loaded byte/halfword is moved down to bit 0 before extension.
  assign lane = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    ReadDataM = 32'd0;
    if (state_q == DONE && !we_q) begin
      case (funct3_q)
        3'b000:  ReadDataM = {{24{lane[7]}}, lane[7:0]};
        3'b001:  ReadDataM = {{16{lane[15]}}, lane[15:0]};
        3'b010:  ReadDataM = lane;
        3'b100:  ReadDataM = {24'd0, lane[7:0]};
        3'b101:  ReadDataM = {16'd0, lane[15:0]};
        default: ReadDataM = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected bus requests, results and faults; a monitor checks them.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        AccessFaultM;
  logic        BusErrM;

  mem_access_unit #(.BUS_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemWriteM    (MemWriteM),
    .ResultSrcM   (ResultSrcM),
    .funct3M      (funct3M),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we   (mem_req_we),
    .mem_req_addr (mem_req_addr),
    .mem_req_be   (mem_req_be),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .ReadDataM    (ReadDataM),
    .StallM       (StallM),
    .AccessFaultM (AccessFaultM),
    .BusErrM      (BusErrM)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   flt_q[$];

  int total = 0;
  int bad   = 0;

  logic        hang_req   = 1'b0;
  logic        hang_rsp   = 1'b0;
  logic        inject_rsp = 1'b0;
  logic [31:0] rsp_data   = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h", name, act, exp);
    end
  endtask

  // Bus model: ready whenever requested, read data one cycle after the read handshake.
  initial begin
    logic hs;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'd0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready && !mem_req_we;
      @(posedge clk);
      #1;
      mem_rsp_valid = (hs && !hang_rsp) || inject_rsp;
      mem_rsp_rdata = rsp_data;
      mem_req_ready = mem_req_valid && !hang_req;
    end
  end

  // Monitor: every bus handshake, fault, and end of a stall run is matched against the queues.
  initial begin
    int   stalls;
    req_t r;
    rsp_t p;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalls = 0;
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          if (req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: act=addr %h req=no request", mem_req_addr);
          end else begin
            r = req_q.pop_front();
            chk("req_we", mem_req_we, r.we);
            chk("req_addr", mem_req_addr, r.addr);
            chk("req_be", mem_req_be, r.be);
            chk("req_wdata", mem_req_wdata, r.wdata);
          end
        end
        if (AccessFaultM) begin
          if (flt_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_fault: act=fault addr %h req=no fault", ALUResultM);
          end else begin
            void'(flt_q.pop_front());
            chk("fault_stall", StallM, 0);
            chk("fault_req_valid", mem_req_valid, 0);
          end
        end
        if (StallM) begin
          stalls++;
          chk("stall_rdata_zero", ReadDataM, 0);
        end else if (stalls > 0) begin
          if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: act=rdata %h req=no completion", ReadDataM);
          end else begin
            p = rsp_q.pop_front();
            chk("done_rdata", ReadDataM, p.rdata);
            chk("done_buserr", BusErrM, p.err);
            chk("done_stalls", stalls, p.stalls);
            chk("done_req_valid", mem_req_valid, 0);
          end
          stalls = 0;
        end else begin
          chk("idle_buserr", BusErrM, 0);
          chk("idle_rdata", ReadDataM, 0);
        end
      end
    end
  end

  task automatic bubble();
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    funct3M    = 3'b000;
    ALUResultM = 32'd0;
    WriteDataM = 32'd0;
  endtask

  task automatic issue(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(posedge clk);
    #1;
    MemWriteM  = mw;
    ResultSrcM = rs;
    funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (StallM && n < 40);
    if (StallM) begin
      total++; bad++;
      $display("FAIL stall_bound: act=still stalled after %0d cycles req=release", n);
    end
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                    input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp);
    rsp_data = rd;
    req_q.push_back('{1'b0, exp_addr, exp_be, 32'd0});
    rsp_q.push_back('{exp, 1'b0, 3});
    issue(1'b0, 2'b01, f3, a, 32'd0);
  endtask

  task automatic st(input logic [1:0] rs, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    req_q.push_back('{1'b1, exp_addr, exp_be, exp_wd});
    rsp_q.push_back('{32'd0, 1'b0, 2});
    issue(1'b1, rs, f3, a, wd);
  endtask

  task automatic flt(input logic mw, input logic [1:0] rs, input logic [2:0] f3, input logic [31:0] a);
    flt_q.push_back(1);
    issue(mw, rs, f3, a, 32'h1234_5678);
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_we", mem_req_we, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_be", mem_req_be, 0);
    chk("rst_req_wdata", mem_req_wdata, 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_buserr", BusErrM, 0);
    chk("rst_stall", StallM, 0);
    #2;
    rst_n = 1'b1;

    ld(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    st(2'b00, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5);
    ld(3'b000, 32'h0000_0002, 32'h0080_0000, 32'h0000_0000, 4'b0100, 32'hFFFF_FF80);
    ld(3'b100, 32'h0000_0002, 32'h0080_0000, 32'h0000_0000, 4'b0100, 32'h0000_0080);
    ld(3'b001, 32'h0000_0002, 32'h8001_0000, 32'h0000_0000, 4'b1100, 32'hFFFF_8001);
    ld(3'b101, 32'h0000_0000, 32'h1234_F00D, 32'h0000_0000, 4'b0011, 32'h0000_F00D);
    ld(3'b000, 32'h0000_0001, 32'h0000_7F00, 32'h0000_0000, 4'b0010, 32'h0000_007F);
    st(2'b00, 3'b001, 32'h0000_0006, 32'h0000_1234, 32'h0000_0004, 4'b1100, 32'h1234_1234);
    st(2'b00, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D);
    st(2'b01, 3'b010, 32'h0000_000C, 32'h55AA_55AA, 32'h0000_000C, 4'b1111, 32'h55AA_55AA);

    flt(1'b0, 2'b01, 3'b010, 32'h0000_0101);
    flt(1'b0, 2'b01, 3'b011, 32'h0000_0000);
    flt(1'b1, 2'b00, 3'b001, 32'h0000_0001);
    flt(1'b1, 2'b00, 3'b110, 32'h0000_0000);

    // Timeout with ready withheld: one IDLE stall plus four REQ cycles.
    hang_req = 1'b1;
    rsp_q.push_back('{32'd0, 1'b1, 5});
    issue(1'b0, 2'b01, 3'b010, 32'h0000_0010, 32'd0);
    hang_req = 1'b0;
    @(posedge clk);
    #1;
    bubble();
    rsp_data   = 32'hFFFF_FFFF;
    inject_rsp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("late_rsp_rdata", ReadDataM, 0);
    chk("late_rsp_buserr", BusErrM, 0);
    chk("late_rsp_stall", StallM, 0);
    inject_rsp = 1'b0;

    // Timeout after handshake while the response never arrives.
    hang_rsp = 1'b1;
    req_q.push_back('{1'b0, 32'h0000_0014, 4'b1111, 32'd0});
    rsp_q.push_back('{32'd0, 1'b1, 5});
    issue(1'b0, 2'b01, 3'b010, 32'h0000_0014, 32'd0);
    hang_rsp = 1'b0;

    // Reset while waiting for read data.
    hang_rsp = 1'b1;
    rsp_data = 32'h1111_2222;
    req_q.push_back('{1'b0, 32'h0000_0020, 4'b1111, 32'd0});
    @(posedge clk);
    #1;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    funct3M    = 3'b010;
    ALUResultM = 32'h0000_0020;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("wait_rsp_stall", StallM, 1);
    rst_n = 1'b0;
    bubble();
    #1;
    chk("mid_rst_req_valid", mem_req_valid, 0);
    chk("mid_rst_stall", StallM, 0);
    @(posedge clk);
    #3;
    rst_n    = 1'b1;
    hang_rsp = 1'b0;
    inject_rsp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_rdata", ReadDataM, 0);
    chk("post_rst_buserr", BusErrM, 0);
    chk("post_rst_stall", StallM, 0);
    chk("post_rst_req_valid", mem_req_valid, 0);
    inject_rsp = 1'b0;

    ld(3'b010, 32'h0000_0040, 32'h0BAD_F00D, 32'h0000_0040, 4'b1111, 32'h0BAD_F00D);
    @(posedge clk);
    #1;
    bubble();
    repeat (3) @(negedge clk);

    chk("req_queue_empty", req_q.size(), 0);
    chk("rsp_queue_empty", rsp_q.size(), 0);
    chk("flt_queue_empty", flt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
